// File: rtl/uart_bytes_tx.sv
// ---------------------------------------------------------------------------
// uart_bytes_tx
//
// Multi-byte UART transmitter. On an accepted start request the whole
// BYTES*8-bit word is captured and sent as BYTES back-to-back 8N1 frames.
// The low byte goes first and each byte is sent LSB first.
//
// Ports
//   sys_clk          system clock
//   sys_rst_n        asynchronous active-low reset
//   uart_bytes_en    start request; accepted only while not busy
//   uart_bytes_data  word to send; captured when the start is accepted
//   uart_bytes_busy  high while a transfer is in progress (registered)
//   uart_bytes_done  one-cycle pulse when the last stop bit has completed
//   uart_txd         serial line, registered, idle high
//
// States
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | line idle high, waiting for a start request
//   S_START | driving the start bit (low) for one bit period
//   S_DATA  | driving d0..d7 of the current low byte, one bit period each
//   S_STOP  | driving the stop bit (high); then next byte or back to idle
// ---------------------------------------------------------------------------
module uart_bytes_tx #(
    parameter int BYTES   = 5,
    parameter int BPS     = 9600,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_bytes_en,
    input  logic [BYTES*8-1:0]   uart_bytes_data,
    output logic                 uart_bytes_busy,
    output logic                 uart_bytes_done,
    output logic                 uart_txd
);

    localparam int BAUD_CNT = CLK_FRE / BPS;
    localparam int CW       = $clog2(BAUD_CNT);
    localparam int W        = BYTES * 8;

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [9:0]    LAST_BYTE = 10'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [9:0]      byte_cnt;
    logic [W-1:0]    shift_reg;

    logic            baud_tick;
    logic [2:0]      next_bit;
    logic [7:0]      cur_byte;

    // The byte being sent always sits in the low 8 bits of the shift
    // register; bits are picked by index rather than shifting per bit.
    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign next_bit  = bit_cnt + 3'd1;
    assign cur_byte  = shift_reg[7:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= S_IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            shift_reg       <= '0;
            uart_txd        <= 1'b1;
            uart_bytes_busy <= 1'b0;
            uart_bytes_done <= 1'b0;
        end else begin
            uart_bytes_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (uart_bytes_en) begin
                        shift_reg       <= uart_bytes_data;
                        byte_cnt        <= '0;
                        bit_cnt         <= '0;
                        uart_txd        <= 1'b0;
                        uart_bytes_busy <= 1'b1;
                        state           <= S_START;
                    end
                end

                S_START: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_txd <= cur_byte[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= S_STOP;
                        end else begin
                            bit_cnt  <= next_bit;
                            uart_txd <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (byte_cnt < LAST_BYTE) begin
                            // Next byte follows with no idle gap. A logical
                            // shift keeps this legal even when BYTES is 1.
                            shift_reg <= shift_reg >> 8;
                            byte_cnt  <= byte_cnt + 10'd1;
                            uart_txd  <= 1'b0;
                            state     <= S_START;
                        end else begin
                            uart_bytes_busy <= 1'b0;
                            uart_bytes_done <= 1'b1;
                            state           <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state           <= S_IDLE;
                    baud_cnt        <= '0;
                    uart_txd        <= 1'b1;
                    uart_bytes_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bytes_tx.sv
module tb_uart_bytes_tx;

    localparam int BYTES   = 5;
    localparam int CLK_FRE = 1_000_000;
    localparam int BPS     = 100_000;
    localparam int B       = CLK_FRE / BPS;
    localparam int N       = BYTES * 10 * B;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic               en = 1'b0;
    logic [BYTES*8-1:0] data = '0;
    logic               busy, done, txd;

    logic               en1 = 1'b0;
    logic [7:0]         data1 = '0;
    logic               busy1, done1, txd1;

    uart_bytes_tx #(.BYTES(BYTES), .BPS(BPS), .CLK_FRE(CLK_FRE)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .uart_bytes_en(en), .uart_bytes_data(data),
        .uart_bytes_busy(busy), .uart_bytes_done(done), .uart_txd(txd)
    );

    uart_bytes_tx #(.BYTES(1), .BPS(BPS), .CLK_FRE(CLK_FRE)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .uart_bytes_en(en1), .uart_bytes_data(data1),
        .uart_bytes_busy(busy1), .uart_bytes_done(done1), .uart_txd(txd1)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer accepted at edge k produces frame j
    // starting at edge k + 10*B*j carrying byte j of the word, busy for
    // edges k..k+N-1, done visible after edge k+N, next accept at k+N+1.
    typedef struct {
        int         edge_no;
        logic [7:0] val;
    } frame_t;

    frame_t frame_q[$];
    int     done_q[$];
    int     busy_lo = -1;
    int     busy_hi = -2;
    int     free_at = 0;
    frame_t f_new;

    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (!sys_rst_n) begin
            frame_q.delete();
            done_q.delete();
            free_at = 0;
            busy_lo = -1;
            busy_hi = -2;
        end else if (en && cyc >= free_at) begin
            for (int j = 0; j < BYTES; j++) begin
                f_new.edge_no = cyc + j * 10 * B;
                f_new.val     = 8'(data >> (8 * j));
                frame_q.push_back(f_new);
            end
            done_q.push_back(cyc + N);
            busy_lo = cyc;
            busy_hi = cyc + N - 1;
            free_at = cyc + N + 1;
        end
    end

    // Monitor: done pulses, busy window, idle line.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", done, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (!(cyc >= busy_lo && cyc <= busy_hi)) check("idle_txd", txd, 1);
        end
    end

    // Monitor: line decoder, samples each bit in the middle of its period.
    int         dec_state = 0;
    int         dec_start = 0;
    int         dec_idx;
    logic [9:0] dec_bits = '0;
    frame_t     cur_f;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            dec_state = 0;
        end else if (dec_state == 0) begin
            if (txd == 1'b0) begin
                dec_state = 1;
                dec_start = cyc;
            end
        end else if ((cyc - dec_start) % B == B / 2) begin
            dec_idx = (cyc - dec_start) / B;
            dec_bits[dec_idx] = txd;
            if (dec_idx == 9) begin
                dec_state = 0;
                if (frame_q.size() == 0) begin
                    check("unexpected_frame", dec_start, -1);
                end else begin
                    cur_f = frame_q.pop_front();
                    check("frame_start", dec_start, cur_f.edge_no);
                    check("frame_byte", dec_bits[8:1], cur_f.val);
                    check("start_bit", dec_bits[0], 0);
                    check("stop_bit", dec_bits[9], 1);
                end
            end
        end
    end

    task automatic send(input logic [BYTES*8-1:0] d);
        @(negedge sys_clk);
        en = 1'b1;
        data = d;
        @(negedge sys_clk);
        en = 1'b0;
        data = {8'($urandom), 32'($urandom)};
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((frame_q.size() != 0 || done_q.size() != 0 || busy) && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check("pending_frames", frame_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [9:0] frame1;
        int         k;
        int         n;

        repeat (3) @(negedge sys_clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Single transfer
        send(40'h55_AA_0F_F0_81);
        wait_idle();
        repeat (10) @(negedge sys_clk);

        // Reset mid-transfer, then a long idle stretch
        send(40'h13_57_9B_DF_24);
        repeat (137) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("post_rst_txd", txd, 1);

        // Ignored start requests and data changes mid-transfer
        send(40'h01_02_03_04_05);
        repeat (2) @(negedge sys_clk);
        en = 1'b1; data = '1;
        @(negedge sys_clk);
        en = 1'b0;
        repeat (246) @(negedge sys_clk);
        en = 1'b1; data = '1;
        @(negedge sys_clk);
        en = 1'b0;
        wait_idle();
        repeat (10) @(negedge sys_clk);

        // Back-to-back with en held high
        @(negedge sys_clk);
        en = 1'b1;
        data = 40'h11_22_33_44_55;
        repeat (3 * (N + 1) + 10) @(negedge sys_clk);
        en = 1'b0;
        wait_idle();

        // Randomized transfers with random gaps and stray requests
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
            send({8'($urandom), 32'($urandom)});
            repeat ($urandom_range(1, N - 2)) @(negedge sys_clk);
            en = 1'b1; data = {8'($urandom), 32'($urandom)};
            @(negedge sys_clk);
            en = 1'b0;
            wait_idle();
        end

        // Single-byte instance: line pattern and done timing
        a5 = 8'hA5;
        frame1 = {1'b1, a5, 1'b0};
        @(negedge sys_clk);
        en1 = 1'b1;
        data1 = a5;
        k = cyc + 1;
        @(negedge sys_clk);
        en1 = 1'b0;
        data1 = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            while (cyc < k + i * 10 + 5) @(negedge sys_clk);
            check("b1_line_bit", txd1, frame1[i]);
            check("b1_busy", busy1, 1);
        end
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("b1_done_cycle", cyc, k + 100);
        check("b1_done_busy", busy1, 0);
        check("b1_done_txd", txd1, 1);
        @(negedge sys_clk);
        check("b1_done_pulse_width", done1, 0);

        repeat (20) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
